// File: rtl/uart_arb_pkg.sv
// Shared types and ASCII constants for the UART TX line arbiter.
// The tag prefix constants are used only when UART_ARB_TAG_EN is defined.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TAG_OPEN,
    TAG_ID,
    TAG_CLOSE,
    TAG_SP,
    LOCKED
  } arb_state_e;

  localparam logic [7:0] CH_LBRACK = 8'h5B;
  localparam logic [7:0] CH_RBRACK = 8'h5D;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_ZERO   = 8'h30;
  localparam logic [7:0] CH_A      = 8'h41;

  // Single hex digit for a requester id: '0'..'9', then 'A'..'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] id);
    if (id < 4'd10) return CH_ZERO + {4'd0, id};
    else            return CH_A + {4'd0, id} - 8'd10;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// searching upward from last+1 with wrap-around.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic               any,
  output logic [IDW-1:0]     idx
);

  int best;

  // NOTE: every output gets a default before the loop so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    best = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      // Distance from the slot right after last; smallest distance wins.
      if (req[j] && ((j - int'(last) - 1 + 2 * NUM_REQ) % NUM_REQ) < best) begin
        best = (j - int'(last) - 1 + 2 * NUM_REQ) % NUM_REQ;
        idx  = IDW'(j);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-locked round-robin arbiter sharing one UART TX byte channel.
// Define UART_ARB_TAG_EN to prefix every granted line with "[<id>] ".
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          NUM_REQ      = 4,
  parameter int          LOCK_TIMEOUT = 1024,
  parameter logic [7:0]  TERM_CHAR    = 8'h0A,
  // Derived from NUM_REQ; not meant to be overridden.
  parameter int          IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_ready_i,
  output logic                   busy_o,
  output logic [IDW-1:0]         grant_id_o
);

  localparam int TW_RAW = $clog2(LOCK_TIMEOUT + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

  arb_state_e     state_q;
  logic [IDW-1:0] grant_q;
  logic [IDW-1:0] last_q;
  logic [TW-1:0]  timer_q;
  logic           pick_any;
  logic [IDW-1:0] pick_idx;
  logic           sel_valid;
  logic [7:0]     sel_data;
`ifdef UART_ARB_TAG_EN
  logic [7:0]     tag_q;
`endif

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req  (req_valid_i),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  assign sel_valid  = req_valid_i[grant_q];
  assign sel_data   = req_data_i[{grant_q, 3'b000} +: 8];
  assign busy_o     = (state_q != IDLE);
  assign grant_id_o = grant_q;

  // The grantee talks straight to the serializer while locked.
  always_comb begin
    tx_valid_o  = 1'b0;
    tx_data_o   = '0;
    req_ready_o = '0;
    if (state_q == LOCKED) begin
      tx_valid_o           = sel_valid;
      tx_data_o            = sel_data;
      req_ready_o[grant_q] = tx_ready_i;
    end
`ifdef UART_ARB_TAG_EN
    else if (state_q != IDLE) begin
      tx_valid_o = 1'b1;
      tx_data_o  = tag_q;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      timer_q <= '0;
`ifdef UART_ARB_TAG_EN
      tag_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q <= pick_idx;
            last_q  <= pick_idx;
            timer_q <= '0;
`ifdef UART_ARB_TAG_EN
            state_q <= TAG_OPEN;
            tag_q   <= CH_LBRACK;
`else
            state_q <= LOCKED;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        // Tag bytes are held in tag_q and advance only on acceptance.
        TAG_OPEN: if (tx_ready_i) begin
          state_q <= TAG_ID;
          tag_q   <= hex_ascii(4'(grant_q));
        end
        TAG_ID: if (tx_ready_i) begin
          state_q <= TAG_CLOSE;
          tag_q   <= CH_RBRACK;
        end
        TAG_CLOSE: if (tx_ready_i) begin
          state_q <= TAG_SP;
          tag_q   <= CH_SPACE;
        end
        TAG_SP: if (tx_ready_i) begin
          state_q <= LOCKED;
        end
`endif
        LOCKED: begin
          if (sel_valid && tx_ready_i && sel_data == TERM_CHAR) begin
            state_q <= IDLE;
          end else if (sel_valid) begin
            timer_q <= '0;
          end else if (LOCK_TIMEOUT != 0 && timer_q == TW'(LOCK_TIMEOUT - 1)) begin
            state_q <= IDLE;
          end else if (timer_q != {TW{1'b1}}) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a line-level
// reference model; honours UART_ARB_TAG_EN for the expected tag prefix.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TO  = 8;
  localparam int IDW = 2;
`ifdef UART_ARB_TAG_EN
  localparam int FIRST_AFTER_GRANT = 1;
`else
  localparam int FIRST_AFTER_GRANT = 5;
`endif
  localparam int LK = 5;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic           busy;
  logic [IDW-1:0] grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .LOCK_TIMEOUT (TO),
    .TERM_CHAR    (8'h0A)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .tx_valid_o  (tx_valid),
    .tx_data_o   (tx_data),
    .tx_ready_i  (tx_ready),
    .busy_o      (busy),
    .grant_id_o  (grant_id)
  );

  int total = 0;
  int bad   = 0;

  // Requester agents: one byte queue each.
  logic [7:0] src_q [N][$];
  logic [N-1:0] gap, stalled;
  int gap_en, rdy_mode, cyc;

  // Reference model: 0 idle, 1..4 tag byte index, LK locked.
  int m_state, m_owner, m_last, m_timer;
  logic m_valid;
  logic [7:0] m_data;
  logic [N-1:0] m_ready;
  logic [7:0] mexp_q[$];

  logic [7:0] out_q[$];
  int out_id_q[$];
  logic prev_stall, prev_busy;
  logic [7:0] prev_data;
  int fall_cyc, x1_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] tag_char(int k, int g);
    case (k)
      1: return "[";
      2: return (g < 10) ? 8'(48 + g) : 8'(65 + g - 10);
      3: return "]";
      default: return " ";
    endcase
  endfunction

  function automatic logic pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) return 1'b1;
    return m_state != 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_owner = 0; m_last = N - 1; m_timer = 0;
  endtask

  task automatic model_comb();
    m_valid = 1'b0; m_data = '0; m_ready = '0;
    if (m_state == LK) begin
      m_valid          = req_valid[m_owner];
      m_data           = req_data[m_owner*8 +: 8];
      m_ready[m_owner] = tx_ready;
    end else if (m_state != 0) begin
      m_valid = 1'b1;
      m_data  = tag_char(m_state, m_owner);
    end
  endtask

  task automatic model_seq();
    logic found;
    int nxt;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && m_ready[i]) begin
        void'(src_q[i].pop_front());
        if (i == 1) x1_cyc = cyc;
        stalled[i] = 1'b0;
      end else begin
        stalled[i] = req_valid[i];
      end
    end
    if (m_valid && tx_ready) mexp_q.push_back(m_data);
    if (m_state == 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        nxt = (m_last + k) % N;
        if (!found && req_valid[nxt]) begin
          found = 1'b1; m_owner = nxt; m_last = nxt; m_timer = 0;
          m_state = FIRST_AFTER_GRANT;
        end
      end
    end else if (m_state != LK) begin
      if (tx_ready) m_state = (m_state == 4) ? LK : m_state + 1;
    end else begin
      if (req_valid[m_owner] && tx_ready && req_data[m_owner*8 +: 8] == 8'h0A) m_state = 0;
      else if (req_valid[m_owner]) m_timer = 0;
      else if (m_timer == TO - 1) m_state = 0;
      else m_timer++;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (!stalled[i]) gap[i] = (gap_en != 0) && ($urandom_range(0, 7) == 0);
      req_valid[i] = (src_q[i].size() > 0) && !gap[i];
      req_data[i*8 +: 8] = req_valid[i] ? src_q[i][0] : 8'($urandom);
    end
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = (cyc % 3 == 0);
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // One clock: drive after the edge, compare on the falling edge, step the model on the rising edge.
  task automatic cycle();
    drive_inputs();
    @(negedge clk);
    model_comb();
    check("tx_valid", 32'(tx_valid), 32'(m_valid));
    check("tx_data", 32'(tx_data), 32'(m_data));
    check("req_ready", 32'(req_ready), 32'(m_ready));
    check("busy", 32'(busy), 32'(m_state != 0));
    check("grant_id", 32'(grant_id), 32'(m_owner));
    if (prev_stall) check("tx_hold", 32'(tx_data), 32'(prev_data));
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    if (tx_valid && tx_ready) begin
      out_q.push_back(tx_data);
      out_id_q.push_back(int'(grant_id));
    end
    if (prev_busy && !busy && fall_cyc < 0) fall_cyc = cyc - 1;
    prev_busy = busy;
    @(posedge clk);
    model_seq();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_valid = '0; tx_ready = 1'b0; gap = '0; stalled = '0; gap_en = 0; rdy_mode = 0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    out_q.delete(); out_id_q.delete(); mexp_q.delete();
    model_reset();
    prev_stall = 1'b0; prev_busy = 1'b0; fall_cyc = -1; x1_cyc = -1;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic push_str(input int r, input string s);
    for (int k = 0; k < s.len(); k++) src_q[r].push_back(s[k]);
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      cycle();
      n++;
    end
    check("drain_budget", 32'(pending()), 32'(0));
  endtask

  task automatic expect_stream(input string s, input string ids);
    check("stream_len", 32'(out_q.size()), 32'(s.len()));
    for (int k = 0; k < s.len() && k < out_q.size(); k++) begin
      check("stream_byte", 32'(out_q[k]), 32'(s[k]));
      check("stream_id", 32'(out_id_q[k]), 32'(int'(ids[k]) - 48));
    end
  endtask

  initial begin
    cyc = 0;
    rst_ni = 1'b0; req_valid = '0; req_data = '0; tx_ready = 1'b0;
    #2;
    check("rst_tx_valid", 32'(tx_valid), 32'(0));
    check("rst_tx_data", 32'(tx_data), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_grant", 32'(grant_id), 32'(0));
    do_reset();
    repeat (3) cycle();

    // Contention: 0 re-requests during 2's line and waits for its release.
    do_reset();
    push_str(0, "AB\nC\n");
    push_str(2, "AB\n");
    run_until_empty(200);
`ifdef UART_ARB_TAG_EN
    expect_stream("[0] AB\n[2] AB\n[0] C\n", "00000002222222000000");
`else
    expect_stream("AB\nAB\nC\n", "00022200");
`endif

    // Backpressure: ready one cycle in three.
    do_reset();
    rdy_mode = 1;
    push_str(1, "XYZ\n");
    run_until_empty(200);
`ifdef UART_ARB_TAG_EN
    expect_stream("[1] XYZ\n", "11111111");
`else
    expect_stream("XYZ\n", "1111");
`endif

    // Lock timeout: requester 1 goes silent mid-line, 3 is waiting.
    do_reset();
    push_str(1, "X");
    push_str(3, "Q\n");
    run_until_empty(200);
    check("timeout_gap", 32'(fall_cyc - x1_cyc), 32'(TO));
`ifdef UART_ARB_TAG_EN
    expect_stream("[1] X[3] Q\n", "11111333333");
`else
    expect_stream("XQ\n", "133");
`endif

    // Reset while the second byte of HELLO is on the bus.
    do_reset();
    push_str(0, "HELLO");
`ifdef UART_ARB_TAG_EN
    for (int n = 0; n < 100 && out_q.size() < 5; n++) cycle();
`else
    for (int n = 0; n < 100 && out_q.size() < 1; n++) cycle();
`endif
    drive_inputs();
    @(negedge clk);
    check("mid_data", 32'(tx_data), 32'("E"));
    rst_ni = 1'b0;
    #1;
    check("mid_tx_valid", 32'(tx_valid), 32'(0));
    check("mid_req_ready", 32'(req_ready), 32'(0));
    check("mid_busy", 32'(busy), 32'(0));
    check("mid_grant", 32'(grant_id), 32'(0));
    do_reset();
    push_str(0, "Z\n");
    push_str(1, "W\n");
    run_until_empty(200);
`ifdef UART_ARB_TAG_EN
    expect_stream("[0] Z\n[1] W\n", "000000111111");
`else
    expect_stream("Z\nW\n", "0011");
`endif

    // Tag prefix (or plain pass-through when the tag is compiled out).
    do_reset();
    push_str(2, "hi\n");
    run_until_empty(200);
`ifdef UART_ARB_TAG_EN
    expect_stream("[2] hi\n", "2222222");
`else
    expect_stream("hi\n", "222");
`endif

    // Randomized traffic, random ready and requester gaps.
    do_reset();
    gap_en = 1;
    rdy_mode = 2;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        int r;
        int len;
        r = $urandom_range(0, N - 1);
        if (src_q[r].size() < 8) begin
          len = $urandom_range(1, 5);
          for (int k = 0; k < len; k++) src_q[r].push_back(8'($urandom_range(32, 126)));
          src_q[r].push_back(8'h0A);
        end
      end
      cycle();
    end
    run_until_empty(4000);
    check("rand_len", 32'(out_q.size()), 32'(mexp_q.size()));
    for (int k = 0; k < out_q.size() && k < mexp_q.size(); k++)
      check("rand_byte", 32'(out_q[k]), 32'(mexp_q[k]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
